// File: rtl/pipe_ctrl_regs_pkg.sv
// Shared types and constants for the RV32I pipeline control/metadata registers.
package pipe_ctrl_regs_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1_addr;
        logic [4:0] rs2_addr;
        logic [4:0] rd_addr;
        logic       rd_wren;
        logic       is_load;
    } stage_ctrl_t;

    localparam stage_ctrl_t STAGE_BUBBLE = '0;

    function automatic logic [4:0] rs1_field(input logic [31:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [4:0] rs2_field(input logic [31:0] instr);
        return instr[24:20];
    endfunction

    function automatic logic [4:0] rd_field(input logic [31:0] instr);
        return instr[11:7];
    endfunction

endpackage

// File: rtl/pipe_ctrl_regs_stage_reg.sv
// Generic pipeline stage register: reset/flush load the bubble value, hold keeps contents.
module pipe_stage_reg #(
    parameter type payload_t = logic
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     hold,
    input  logic     flush,
    input  payload_t d,
    input  payload_t bubble,
    output payload_t q
);

    payload_t q_reg;

    // Flush outranks hold: a held instruction on the wrong path must still be squashed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_reg <= bubble;
        end else if (flush) begin
            q_reg <= bubble;
        end else if (!hold) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/pipe_ctrl_regs.sv
// IF/ID, ID/EX, EX/MEM, MEM/WB control registers plus stall/flush/retire counters.
module pipe_ctrl_regs
    import pipe_ctrl_regs_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter int          PC_W      = 32,
    parameter int          CNT_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             stall_ID,
    input  logic             flush_ID,
    input  logic             flush_EX,
    input  logic             i_ctr_clr,
    input  logic [PC_W-1:0]  IF_pc,
    input  logic [31:0]      IF_instr,
    input  logic             ID_rd_wren,
    input  logic             ID_is_load,
    output logic [PC_W-1:0]  ID_pc,
    output logic [31:0]      ID_instr,
    output logic             ID_valid,
    output logic [4:0]       ID_rs1_addr,
    output logic [4:0]       ID_rs2_addr,
    output logic [4:0]       EX_rs1_addr,
    output logic [4:0]       EX_rs2_addr,
    output logic [4:0]       EX_rd_addr,
    output logic             EX_rd_wren,
    output logic             EX_is_load,
    output logic             EX_valid,
    output logic [4:0]       MEM_rd_addr,
    output logic             MEM_rd_wren,
    output logic             MEM_is_load,
    output logic             MEM_valid,
    output logic [4:0]       WB_rd_addr,
    output logic             WB_rd_wren,
    output logic             WB_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
    } ifid_t;

    ifid_t       if_d, id_q, id_bubble;
    stage_ctrl_t ex_d, ex_q, mem_d, mem_q, wb_d, wb_q;

    assign if_d      = '{valid: 1'b1, pc: IF_pc, instr: IF_instr};
    assign id_bubble = '{valid: 1'b0, pc: '0, instr: NOP_INSTR};

    pipe_stage_reg #(.payload_t(ifid_t)) u_if_id (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .hold   (stall_ID),
        .flush  (flush_ID),
        .d      (if_d),
        .bubble (id_bubble),
        .q      (id_q)
    );

    assign ID_pc       = id_q.pc;
    assign ID_instr    = id_q.instr;
    assign ID_valid    = id_q.valid;
    assign ID_rs1_addr = rs1_field(id_q.instr);
    assign ID_rs2_addr = rs2_field(id_q.instr);

    // Decoder flags are masked by valid; rd=x0 never claims a write so it never forwards.
    always_comb begin
        ex_d          = STAGE_BUBBLE;
        ex_d.valid    = id_q.valid;
        ex_d.rs1_addr = rs1_field(id_q.instr);
        ex_d.rs2_addr = rs2_field(id_q.instr);
        ex_d.rd_addr  = rd_field(id_q.instr);
        ex_d.rd_wren  = ID_rd_wren & id_q.valid & (rd_field(id_q.instr) != 5'd0);
        ex_d.is_load  = ID_is_load & id_q.valid;
    end

    pipe_stage_reg #(.payload_t(stage_ctrl_t)) u_id_ex (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .hold   (1'b0),
        .flush  (flush_EX),
        .d      (ex_d),
        .bubble (STAGE_BUBBLE),
        .q      (ex_q)
    );

    always_comb begin
        mem_d         = STAGE_BUBBLE;
        mem_d.valid   = ex_q.valid;
        mem_d.rd_addr = ex_q.rd_addr;
        mem_d.rd_wren = ex_q.rd_wren;
        mem_d.is_load = ex_q.is_load;
    end

    pipe_stage_reg #(.payload_t(stage_ctrl_t)) u_ex_mem (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .hold   (1'b0),
        .flush  (1'b0),
        .d      (mem_d),
        .bubble (STAGE_BUBBLE),
        .q      (mem_q)
    );

    always_comb begin
        wb_d         = STAGE_BUBBLE;
        wb_d.valid   = mem_q.valid;
        wb_d.rd_addr = mem_q.rd_addr;
        wb_d.rd_wren = mem_q.rd_wren;
    end

    pipe_stage_reg #(.payload_t(stage_ctrl_t)) u_mem_wb (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .hold   (1'b0),
        .flush  (1'b0),
        .d      (wb_d),
        .bubble (STAGE_BUBBLE),
        .q      (wb_q)
    );

    assign EX_rs1_addr = ex_q.rs1_addr;
    assign EX_rs2_addr = ex_q.rs2_addr;
    assign EX_rd_addr  = ex_q.rd_addr;
    assign EX_rd_wren  = ex_q.rd_wren;
    assign EX_is_load  = ex_q.is_load;
    assign EX_valid    = ex_q.valid;
    assign MEM_rd_addr = mem_q.rd_addr;
    assign MEM_rd_wren = mem_q.rd_wren;
    assign MEM_is_load = mem_q.is_load;
    assign MEM_valid   = mem_q.valid;
    assign WB_rd_addr  = wb_q.rd_addr;
    assign WB_rd_wren  = wb_q.rd_wren;
    assign WB_valid    = wb_q.valid;

    // Later stages carry only the fields that follow the instruction downstream.
    logic unused_stage_bits;
    assign unused_stage_bits = ^{mem_q.rs1_addr, mem_q.rs2_addr,
                                 wb_q.rs1_addr, wb_q.rs2_addr, wb_q.is_load};

    // Counter index: 0 = stall, 1 = flush, 2 = instret.
    logic [2:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg [3];

    assign cnt_inc = {wb_q.valid, flush_ID, stall_ID & ~flush_ID};

    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        always_ff @(posedge i_clk) begin
            if (!i_rst_n || i_ctr_clr) begin
                cnt_reg[gi] <= '0;
            end else if (cnt_inc[gi]) begin
                cnt_reg[gi] <= cnt_reg[gi] + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stall_cnt   = cnt_reg[0];
    assign flush_cnt   = cnt_reg[1];
    assign instret_cnt = cnt_reg[2];

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Directed bench for pipe_ctrl_regs (4-bit counters so retire wrap is reachable).
module tb_pipe_ctrl_regs;

    localparam int PC_W  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n, stall_ID, flush_ID, flush_EX, ctr_clr;
    logic [PC_W-1:0]  IF_pc;
    logic [31:0]      IF_instr;
    logic             ID_rd_wren, ID_is_load;
    logic [PC_W-1:0]  ID_pc;
    logic [31:0]      ID_instr;
    logic             ID_valid;
    logic [4:0]       ID_rs1_addr, ID_rs2_addr;
    logic [4:0]       EX_rs1_addr, EX_rs2_addr, EX_rd_addr;
    logic             EX_rd_wren, EX_is_load, EX_valid;
    logic [4:0]       MEM_rd_addr;
    logic             MEM_rd_wren, MEM_is_load, MEM_valid;
    logic [4:0]       WB_rd_addr;
    logic             WB_rd_wren, WB_valid;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, instret_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_ctrl_regs #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .stall_ID    (stall_ID),
        .flush_ID    (flush_ID),
        .flush_EX    (flush_EX),
        .i_ctr_clr   (ctr_clr),
        .IF_pc       (IF_pc),
        .IF_instr    (IF_instr),
        .ID_rd_wren  (ID_rd_wren),
        .ID_is_load  (ID_is_load),
        .ID_pc       (ID_pc),
        .ID_instr    (ID_instr),
        .ID_valid    (ID_valid),
        .ID_rs1_addr (ID_rs1_addr),
        .ID_rs2_addr (ID_rs2_addr),
        .EX_rs1_addr (EX_rs1_addr),
        .EX_rs2_addr (EX_rs2_addr),
        .EX_rd_addr  (EX_rd_addr),
        .EX_rd_wren  (EX_rd_wren),
        .EX_is_load  (EX_is_load),
        .EX_valid    (EX_valid),
        .MEM_rd_addr (MEM_rd_addr),
        .MEM_rd_wren (MEM_rd_wren),
        .MEM_is_load (MEM_is_load),
        .MEM_valid   (MEM_valid),
        .WB_rd_addr  (WB_rd_addr),
        .WB_rd_wren  (WB_rd_wren),
        .WB_valid    (WB_valid),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .instret_cnt (instret_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flush bubbles through every stage, then clear counters.
    task automatic drain();
        stall_ID = 1'b0; flush_EX = 1'b0; flush_ID = 1'b1;
        ID_rd_wren = 1'b0; ID_is_load = 1'b0;
        repeat (5) tick();
        ctr_clr = 1'b1;
        tick();
        ctr_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; stall_ID = 1'b0; flush_ID = 1'b0; flush_EX = 1'b0; ctr_clr = 1'b0;
        IF_pc = 32'h0000_0100; IF_instr = 32'h0010_0093;
        ID_rd_wren = 1'b0; ID_is_load = 1'b0;
        #2;
        tick(); tick();

        // Reset state
        check("rst_id_instr", 64'(ID_instr), 64'h13);
        check("rst_id_pc", 64'(ID_pc), 64'h0);
        check("rst_valids", 64'({ID_valid, EX_valid, MEM_valid, WB_valid}), 64'h0);
        check("rst_cnts", 64'({stall_cnt, flush_cnt, instret_cnt}), 64'h0);

        // addi x1,x0,1 travels IF/ID -> WB with no hazards
        rst_n = 1'b1;
        tick();
        check("t1_id_instr", 64'(ID_instr), 64'h0010_0093);
        check("t1_id_pc", 64'(ID_pc), 64'h100);
        check("t1_id_rs2", 64'(ID_rs2_addr), 64'd1);
        flush_ID = 1'b1; ID_rd_wren = 1'b1;
        tick();
        check("t1_ex_ctrl", 64'({EX_valid, EX_rd_wren, EX_rd_addr}), 64'({1'b1, 1'b1, 5'd1}));
        ID_rd_wren = 1'b0;
        tick(); tick();
        check("t1_wb_ctrl", 64'({WB_valid, WB_rd_wren, WB_rd_addr}), 64'({1'b1, 1'b1, 5'd1}));
        tick();
        check("t1_instret", 64'(instret_cnt), 64'd1);
        check("t1_flush_cnt", 64'(flush_cnt), 64'd4);

        // Load-use: lw x5,0(x1) then add x6,x5,x5 held in ID with an EX bubble
        drain();
        flush_ID = 1'b0; IF_instr = 32'h0000_A283;
        tick();
        IF_instr = 32'h0052_8333; ID_is_load = 1'b1; ID_rd_wren = 1'b1;
        tick();
        check("t2_ex_load", 64'({EX_is_load, EX_rd_addr}), 64'({1'b1, 5'd5}));
        stall_ID = 1'b1; flush_EX = 1'b1; ID_is_load = 1'b0;
        IF_instr = 32'hDEAD_BEEF;
        tick();
        check("t2_id_held", 64'(ID_instr), 64'h0052_8333);
        check("t2_ex_bubble", 64'({EX_valid, EX_rd_wren}), 64'h0);
        check("t2_mem_load", 64'({MEM_valid, MEM_is_load, MEM_rd_addr}), 64'({1'b1, 1'b1, 5'd5}));
        check("t2_stall_cnt", 64'(stall_cnt), 64'd1);
        stall_ID = 1'b0; flush_EX = 1'b0;
        tick();
        check("t2_ex_add", 64'({EX_rs1_addr, EX_rs2_addr, EX_rd_addr}), 64'({5'd5, 5'd5, 5'd6}));

        // flush_ID together with stall_ID: flush wins
        drain();
        flush_ID = 1'b0; IF_instr = 32'h0052_8333;
        tick();
        check("t3_id_valid_pre", 64'(ID_valid), 64'd1);
        flush_ID = 1'b1; stall_ID = 1'b1;
        tick();
        check("t3_id_instr", 64'(ID_instr), 64'h13);
        check("t3_id_valid", 64'(ID_valid), 64'd0);
        check("t3_flush_cnt", 64'(flush_cnt), 64'd1);
        check("t3_stall_cnt", 64'(stall_cnt), 64'd0);

        // addi x0,x0,5 with decoder rd_wren=1: no write enable, still retires
        drain();
        flush_ID = 1'b0; IF_instr = 32'h0050_0013;
        tick();
        flush_ID = 1'b1; ID_rd_wren = 1'b1;
        tick();
        check("t4_ex_ctrl", 64'({EX_valid, EX_rd_wren, EX_rd_addr}), 64'({1'b1, 1'b0, 5'd0}));
        ID_rd_wren = 1'b0;
        tick(); tick();
        check("t4_wb_ctrl", 64'({WB_valid, WB_rd_wren}), 64'({1'b1, 1'b0}));
        tick();
        check("t4_instret", 64'(instret_cnt), 64'd1);

        // Continuous retire: 4-bit instret wraps 15 -> 0, clear beats increment
        drain();
        flush_ID = 1'b0; IF_instr = 32'h0010_0093; ID_rd_wren = 1'b1;
        repeat (19) tick();
        check("t5_instret_15", 64'(instret_cnt), 64'd15);
        tick();
        check("t5_instret_wrap", 64'(instret_cnt), 64'd0);
        ctr_clr = 1'b1;
        tick();
        check("t5_clr_wins", 64'(instret_cnt), 64'd0);
        check("t5_clr_pipe", 64'(WB_valid), 64'd1);
        ctr_clr = 1'b0;
        tick();
        check("t5_resume", 64'(instret_cnt), 64'd1);

        // Reset mid-stream with all stages valid and a stall asserted
        check("t6_full_pre", 64'({ID_valid, EX_valid, MEM_valid, WB_valid}), 64'hF);
        rst_n = 1'b0; stall_ID = 1'b1;
        tick();
        check("t6_id_instr", 64'(ID_instr), 64'h13);
        check("t6_valids", 64'({ID_valid, EX_valid, MEM_valid, WB_valid}), 64'h0);
        check("t6_wrens", 64'({EX_rd_wren, MEM_rd_wren, WB_rd_wren, EX_is_load, MEM_is_load}), 64'h0);
        check("t6_cnts", 64'({stall_cnt, flush_cnt, instret_cnt}), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
